// File: rtl/ssd_block_engine.sv
// Block SSD engine: one row per cycle into a 3-stage diff/square/accumulate pipe.
// Optional early termination compiled in with `define SSD_EARLY_TERM_EN.
module ssd_block_engine #(
  parameter  int BLOCK_SIZE = 6,
  parameter  int PIX_W      = 8,
  localparam int SSD_W      = $clog2(64'(BLOCK_SIZE) * 64'(BLOCK_SIZE)
                                     * ((64'd1 << PIX_W) - 64'd1) ** 2
                                     + 64'd1)
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        flush_in,
  input  logic                        row_valid_in,
  output logic                        row_ready_out,
  input  logic [BLOCK_SIZE*PIX_W-1:0] left_row_in,
  input  logic [BLOCK_SIZE*PIX_W-1:0] right_row_in,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [SSD_W-1:0]            ssd_out
`ifdef SSD_EARLY_TERM_EN
  ,
  input  logic [SSD_W-1:0]            threshold_in,
  output logic                        early_term_out
`endif
);

  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_last;
  logic          w_hs;
  logic          w_frozen;

  logic [BLOCK_SIZE-1:0][PIX_W:0]     r_d1;
  logic [BLOCK_SIZE-1:0][PIX_W:0]     w_d;
  logic [BLOCK_SIZE-1:0][2*PIX_W-1:0] r_sq2;
  logic [BLOCK_SIZE-1:0][2*PIX_W-1:0] w_sq;
  logic [SSD_W-1:0]                   r_acc;
  logic [SSD_W-1:0]                   w_rowsum;
  logic [SSD_W-1:0]                   w_sum;

  logic r_v1;
  logic r_l1;
  logic r_v2;
  logic r_l2;
  logic r_l3;

  function automatic logic [2*PIX_W-1:0] sq(
    input logic [PIX_W:0] d
  );
    logic [PIX_W-1:0] m;
    m = d[PIX_W] ? PIX_W'(-d) : d[PIX_W-1:0];
    return (2*PIX_W)'(m) * (2*PIX_W)'(m);
  endfunction

  assign row_ready_out = (r_state == ACCUM) && rst_n_in;
  assign w_accept      = row_valid_in && row_ready_out;
  assign w_last        = (r_cnt == CW'(BLOCK_SIZE - 1));
  assign w_hs          = (r_state == DONE) && ready_in;
  assign ssd_out       = r_acc;

  always_comb begin
    w_d      = '0;
    w_sq     = '0;
    w_rowsum = '0;
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      w_d[c]   = {1'b0, left_row_in[c*PIX_W +: PIX_W]}
               - {1'b0, right_row_in[c*PIX_W +: PIX_W]};
      w_sq[c]  = sq(r_d1[c]);
      w_rowsum = w_rowsum + SSD_W'(r_sq2[c]);
    end
  end

  assign w_sum = r_acc + w_rowsum;

`ifdef SSD_EARLY_TERM_EN
  logic [SSD_W-1:0] r_thr;
  logic             r_term;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_thr  <= '0;
      r_term <= 1'b0;
    end else if (flush_in || w_hs) begin
      r_term <= 1'b0;
    end else begin
      if (w_accept && (r_cnt == '0))
        r_thr <= threshold_in;
      if (r_v2 && !r_term && (w_sum > r_thr))
        r_term <= 1'b1;
    end
  end

  assign w_frozen       = r_term;
  assign early_term_out = r_term && (r_state == DONE);
`else
  assign w_frozen = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_state <= ACCUM;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACCUM:   if (w_accept && w_last) w_next = DRAIN;
      DRAIN:   if (r_l3) w_next = DONE;
      DONE:    if (ready_in) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
    if (flush_in)
      w_next = ACCUM;
  end

  always_comb begin
    valid_out = 1'b0;
    unique case (1'b1)
      (r_state == DONE): valid_out = 1'b1;
      default:           valid_out = 1'b0;
    endcase
  end

  // r_l* tags the final row through the pipe so DRAIN knows when to finish
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
      r_d1  <= '0;
      r_sq2 <= '0;
      r_acc <= '0;
      r_v1  <= 1'b0;
      r_l1  <= 1'b0;
      r_v2  <= 1'b0;
      r_l2  <= 1'b0;
      r_l3  <= 1'b0;
    end else if (flush_in) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_v1  <= 1'b0;
      r_l1  <= 1'b0;
      r_v2  <= 1'b0;
      r_l2  <= 1'b0;
      r_l3  <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      r_l1 <= w_accept && w_last;
      if (w_accept) begin
        r_d1  <= w_d;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      if (r_v1)
        r_sq2 <= w_sq;
      r_l3 <= r_v2 && r_l2;
      if (w_hs) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_v2 && !w_frozen) begin
        r_acc <= w_sum;
      end
    end
  end

endmodule
